// File: rtl/mux_arb.sv
// mux_arb: packet-level round-robin arbiter for the 2:1 router output mux.
// Locks the mux from head to tail and polices framing with a length watchdog.
module mux_arb #(
    parameter int MAXLEN = 32,
    parameter int CNTW   = 6,
    parameter int TYPEW  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ivalid_0,
    input  logic [TYPEW-1:0] itype_0,
    input  logic             ivalid_1,
    input  logic [TYPEW-1:0] itype_1,
    input  logic             oready,
    output logic [1:0]       sel,
    output logic             iready_0,
    output logic             iready_1,
    output logic             busy,
    output logic             err_len,
    output logic             err_proto
);

    // Flit type encoding shared with the router: NONE=0, HEAD=1, DATA=2, TAIL=3.
    localparam logic [TYPEW-1:0] TYPE_HEAD = TYPEW'(1);
    localparam logic [TYPEW-1:0] TYPE_TAIL = TYPEW'(3);
    localparam logic [CNTW-1:0]  CNT_MAX   = CNTW'(MAXLEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [CNTW-1:0]   cnt_inc;
    logic              err_len_d, err_proto_d;
    logic [1:0]        sel_d;
    logic              busy_d;
    logic              head_0, head_1;
    logic              stray_0, stray_1;
    logic              xfer_0, xfer_1;

    assign head_0  = ivalid_0 && (itype_0 == TYPE_HEAD);
    assign head_1  = ivalid_1 && (itype_1 == TYPE_HEAD);
    assign stray_0 = ivalid_0 && (itype_0 != TYPE_HEAD);
    assign stray_1 = ivalid_1 && (itype_1 != TYPE_HEAD);
    assign xfer_0  = ivalid_0 && iready_0;
    assign xfer_1  = ivalid_1 && iready_1;
    assign cnt_inc = cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            sel       <= 2'b00;
            busy      <= 1'b0;
            err_len   <= 1'b0;
            err_proto <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            sel       <= sel_d;
            busy      <= busy_d;
            err_len   <= err_len_d;
            err_proto <= err_proto_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        err_len_d   = 1'b0;
        err_proto_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                err_proto_d = stray_0 || stray_1;
                // On a tie, the input not granted last time wins.
                if (head_0 && (!head_1 || last_q)) begin
                    state_d = LOCK0;
                    last_d  = 1'b0;
                    cnt_d   = '0;
                end else if (head_1) begin
                    state_d = LOCK1;
                    last_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            LOCK0: begin
                if (xfer_0) begin
                    cnt_d = cnt_inc;
                    if (itype_0 == TYPE_TAIL) begin
                        state_d = IDLE;
                    end else if (cnt_inc == CNT_MAX) begin
                        state_d   = IDLE;
                        err_len_d = 1'b1;
                    end
                end
            end
            LOCK1: begin
                if (xfer_1) begin
                    cnt_d = cnt_inc;
                    if (itype_1 == TYPE_TAIL) begin
                        state_d = IDLE;
                    end else if (cnt_inc == CNT_MAX) begin
                        state_d   = IDLE;
                        err_len_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        iready_0 = 1'b0;
        iready_1 = 1'b0;
        sel_d    = 2'b00;
        busy_d   = (state_d != IDLE);
        unique case (state_q)
            IDLE: begin
                // Non-head flits outside a packet are drained and dropped.
                iready_0 = stray_0;
                iready_1 = stray_1;
            end
            LOCK0:   iready_0 = oready;
            LOCK1:   iready_1 = oready;
            default: ;
        endcase
        unique case (state_d)
            LOCK0:   sel_d = 2'b01;
            LOCK1:   sel_d = 2'b10;
            default: sel_d = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_mux_arb.sv
// tb_mux_arb: scoreboard bench for mux_arb.
// Expected output flits are queued when packets are sent and checked on transfer.
module tb_mux_arb;

    localparam int MAXLEN = 32;
    localparam int HEAD   = 1;
    localparam int DATA   = 2;
    localparam int TAIL   = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ivalid_0 = 1'b0;
    logic [1:0] itype_0 = 2'd0;
    logic       ivalid_1 = 1'b0;
    logic [1:0] itype_1 = 2'd0;
    logic       oready = 1'b1;
    logic [1:0] sel;
    logic       iready_0, iready_1, busy, err_len, err_proto;

    always #5 clk = ~clk;

    mux_arb #(.MAXLEN(MAXLEN), .CNTW(6), .TYPEW(2)) dut (
        .clk(clk), .rst(rst),
        .ivalid_0(ivalid_0), .itype_0(itype_0),
        .ivalid_1(ivalid_1), .itype_1(itype_1),
        .oready(oready), .sel(sel),
        .iready_0(iready_0), .iready_1(iready_1),
        .busy(busy), .err_len(err_len), .err_proto(err_proto)
    );

    typedef struct {
        int port;
        int ty;
    } exp_t;

    exp_t sb[$];
    int   src0[$];
    int   src1[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int tx_cnt, sel_cnt, proto_cnt, len_cnt;
    int first_tx, last_tx, last_tail, gap, pkt_cnt, stray_cyc;
    bit pend_proto = 0;
    bit pend_len = 0;
    bit rst_req = 1;
    bit toggle = 0;
    bit ordy = 1;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic send(int port, int n, int nout);
        for (int i = 0; i < n; i++) begin
            int   t;
            exp_t e;
            t = (i == 0) ? HEAD : (i == n - 1) ? TAIL : DATA;
            if (port == 0) src0.push_back(t);
            else src1.push_back(t);
            if (i < nout) begin
                e.port = port;
                e.ty   = t;
                sb.push_back(e);
            end
        end
    endtask

    task automatic begin_test();
        tx_cnt    = 0;
        sel_cnt   = 0;
        proto_cnt = 0;
        len_cnt   = 0;
        first_tx  = -1;
        last_tx   = -1;
        stray_cyc = -1;
    endtask

    task automatic observe(int p, logic v, logic r, logic [1:0] t);
        exp_t e;
        if (!(v && r)) return;
        if (sel == 2'b00) begin
            check("stray_is_head", 32'(t == 2'(HEAD)), 0);
            pend_proto = 1;
            stray_cyc  = cyc;
        end else begin
            if (sb.size() == 0) begin
                check("sb_empty", 1, 0);
            end else begin
                e = sb.pop_front();
                check("out_sel", sel, 32'(1 << e.port));
                check("out_port", p, e.port);
                check("out_type", t, e.ty);
            end
            tx_cnt++;
            if (first_tx < 0) first_tx = cyc;
            last_tx = cyc;
            if (t == 2'(HEAD)) gap = cyc - last_tail;
            pkt_cnt++;
            if (t == 2'(TAIL)) begin
                pkt_cnt   = 0;
                last_tail = cyc;
            end else if (pkt_cnt == MAXLEN) begin
                pend_len = 1;
                pkt_cnt  = 0;
            end
        end
        if (p == 0) void'(src0.pop_front());
        else void'(src1.pop_front());
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        check("err_proto", err_proto, pend_proto);
        check("err_len", err_len, pend_len);
        check("busy_vs_sel", busy, 32'(sel != 2'b00));
        check("sel_onehot", 32'(sel != 2'b11), 1);
        if (err_proto) proto_cnt++;
        if (err_len) len_cnt++;
        if (sel != 2'b00) sel_cnt++;
        pend_proto = 0;
        pend_len   = 0;
        rst  = rst_req;
        ordy = toggle ? ~ordy : 1'b1;
        oready = ordy;
        if (rst_req) begin
            ivalid_0 = 1'b0;
            ivalid_1 = 1'b0;
        end else begin
            ivalid_0 = (src0.size() > 0);
            itype_0  = (src0.size() > 0) ? 2'(src0[0]) : 2'd0;
            ivalid_1 = (src1.size() > 0);
            itype_1  = (src1.size() > 0) ? 2'(src1[0]) : 2'd0;
        end
        #1;
        if (!rst_req) begin
            observe(0, ivalid_0, iready_0, itype_0);
            observe(1, ivalid_1, iready_1, itype_1);
        end else begin
            pkt_cnt = 0;
        end
    endtask

    task automatic drain(int budget);
        int n = 0;
        while ((sb.size() > 0 || src0.size() > 0 || src1.size() > 0) && n < budget) begin
            step();
            n++;
        end
        if (sb.size() > 0 || src0.size() > 0 || src1.size() > 0) begin
            check("drain_timeout", 1, 0);
            sb.delete();
            src0.delete();
            src1.delete();
        end
        repeat (3) step();
    endtask

    task automatic do_reset();
        rst_req = 1;
        step();
        step();
        rst_req = 0;
        sb.delete();
        src0.delete();
        src1.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int t0;
        last_tail = 0;
        gap = 0;
        pkt_cnt = 0;

        // reset values
        do_reset();
        check("rst_sel", sel, 0);
        check("rst_busy", busy, 0);
        check("rst_err_len", err_len, 0);
        check("rst_err_proto", err_proto, 0);
        check("rst_iready_0", iready_0, 0);
        check("rst_iready_1", iready_1, 0);

        // single 22-flit packet on input 1
        begin_test();
        send(1, 22, 22);
        t0 = cyc;
        drain(100);
        check("t1_first_tx", first_tx, t0 + 2);
        check("t1_tx", tx_cnt, 22);
        check("t1_sel_cycles", sel_cnt, 22);
        check("t1_proto", proto_cnt, 0);
        check("t1_len", len_cnt, 0);

        // simultaneous heads after reset: input 0 first, then 1, then 0 again
        do_reset();
        begin_test();
        send(0, 4, 4);
        send(1, 5, 5);
        drain(100);
        check("t2_bubble", gap, 2);
        check("t2_tx", tx_cnt, 9);
        send(0, 3, 3);
        send(1, 3, 3);
        drain(100);
        check("t2_tx_total", tx_cnt, 15);
        check("t2_proto", proto_cnt, 0);

        // oready toggling during a 10-flit packet
        begin_test();
        toggle = 1;
        send(0, 10, 10);
        drain(100);
        toggle = 0;
        check("t3_tx", tx_cnt, 10);
        check("t3_span", last_tx - first_tx + 1, 19);
        check("t3_len", len_cnt, 0);

        // 40-flit packet trips the watchdog at 32
        begin_test();
        send(0, 40, 32);
        drain(200);
        check("t4_tx", tx_cnt, 32);
        check("t4_len", len_cnt, 1);
        check("t4_proto", proto_cnt, 8);

        // stray DATA on input 0 alongside a head on input 1
        begin_test();
        src0.push_back(DATA);
        send(1, 3, 3);
        t0 = cyc;
        drain(100);
        check("t5_stray_cyc", stray_cyc, t0 + 1);
        check("t5_first_tx", first_tx, t0 + 2);
        check("t5_proto", proto_cnt, 1);
        check("t5_tx", tx_cnt, 3);

        // reset in the middle of a locked packet
        begin_test();
        send(1, 10, 10);
        for (int i = 0; i < 50 && tx_cnt < 4; i++) step();
        check("t6_pre_tx", tx_cnt, 4);
        rst_req = 1;
        step();
        rst_req = 0;
        sb.delete();
        src0.delete();
        src1.delete();
        step();
        check("t6_sel", sel, 0);
        check("t6_busy", busy, 0);
        check("t6_err_len", err_len, 0);
        check("t6_err_proto", err_proto, 0);
        send(0, 3, 3);
        send(1, 3, 3);
        drain(100);
        check("t6_tx", tx_cnt, 10);
        check("t6_proto", proto_cnt, 0);
        check("t6_len", len_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
